// File: rtl/flex_counter_pkg.sv
// rtl/flex_counter_pkg.sv - shared types for the multi-channel flex counter
package flex_counter_pkg;

  // Count direction, one bit per channel
  typedef logic dir_t;
  localparam dir_t DIR_UP   = 1'b0;
  localparam dir_t DIR_DOWN = 1'b1;

  // Which source feeds a channel's next count, in priority order
  typedef enum logic [2:0] {
    NV_HOLD,
    NV_CLEAR,
    NV_LOAD,
    NV_STEP,
    NV_WRAP
  } nv_sel_t;

endpackage

// File: rtl/flex_counter_channel.sv
// rtl/flex_counter_channel.sv - one W-bit up/down counter with rollover flag and wrap pulse
module flex_counter_channel
  import flex_counter_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic         count_enable,
  input  logic         tick,
  input  dir_t         dir,
  input  logic [W-1:0] start_val,
  input  logic [W-1:0] rollover_val,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         rollover_flag,
  output logic         wrap_pulse
);

  localparam logic [W-1:0] ONE = W'(1);

  nv_sel_t      sel;
  logic [W-1:0] next_count;

  // Pick the next-value source (clear > load > count) and form the next count
  always_comb begin
    sel        = NV_HOLD;
    next_count = count;
    if (clear) begin
      sel = NV_CLEAR;
    end else if (load) begin
      sel = NV_LOAD;
    end else if (count_enable && tick) begin
      sel = (count == rollover_val) ? NV_WRAP : NV_STEP;
    end
    case (sel)
      NV_CLEAR: next_count = start_val;
      NV_LOAD:  next_count = load_val;
      NV_WRAP:  next_count = start_val;
      NV_STEP:  next_count = (dir == DIR_DOWN) ? count - ONE : count + ONE;
      default:  next_count = count;
    endcase
  end

  // Register count, flag and pulse; reset drops any pending wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      count         <= start_val;
      rollover_flag <= 1'b0;
      wrap_pulse    <= 1'b0;
    end else begin
      count         <= next_count;
      rollover_flag <= (next_count == rollover_val);
      wrap_pulse    <= (sel == NV_WRAP);
    end
  end

endmodule

// File: rtl/flex_counter_multi.sv
// rtl/flex_counter_multi.sv - NUM_CH programmable counters, optional shared prescaler (FLEX_CNT_PRESCALE_EN)
module flex_counter_multi
  import flex_counter_pkg::*;
#(
  parameter int NUM_CNT_BITS = 4,
  parameter int NUM_CH       = 2,
  parameter int PRESCALE_W   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CH-1:0]              clear,
  input  logic [NUM_CH-1:0]              load,
  input  logic [NUM_CH-1:0]              count_enable,
  input  logic [NUM_CH-1:0]              dir,
  input  logic [NUM_CH*NUM_CNT_BITS-1:0] start_val,
  input  logic [NUM_CH*NUM_CNT_BITS-1:0] rollover_val,
  input  logic [NUM_CH*NUM_CNT_BITS-1:0] load_val,
`ifdef FLEX_CNT_PRESCALE_EN
  input  logic [PRESCALE_W-1:0]          prescale_val,
`endif
  output logic [NUM_CH*NUM_CNT_BITS-1:0] count_out,
  output logic [NUM_CH-1:0]              rollover_flag,
  output logic [NUM_CH-1:0]              wrap_pulse,
  output logic                           wrap_any
);

  logic tick;

`ifdef FLEX_CNT_PRESCALE_EN
  logic [PRESCALE_W-1:0] pre_cnt;

  assign tick = (pre_cnt == prescale_val);

  // Shared prescaler: 0..prescale_val, restarts after the tick; a lowered
  // prescale_val lets it run on through the natural wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRESCALE_W'(1);
    end
  end
`else
  // No prescaler: true for any legal PRESCALE_W, so every cycle is a tick
  assign tick = (PRESCALE_W >= 1);
`endif

  genvar c;
  generate
    for (c = 0; c < NUM_CH; c++) begin : g_ch
      flex_counter_channel #(
        .W(NUM_CNT_BITS)
      ) u_ch (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear[c]),
        .load         (load[c]),
        .count_enable (count_enable[c]),
        .tick         (tick),
        .dir          (dir[c]),
        .start_val    (start_val[c*NUM_CNT_BITS +: NUM_CNT_BITS]),
        .rollover_val (rollover_val[c*NUM_CNT_BITS +: NUM_CNT_BITS]),
        .load_val     (load_val[c*NUM_CNT_BITS +: NUM_CNT_BITS]),
        .count        (count_out[c*NUM_CNT_BITS +: NUM_CNT_BITS]),
        .rollover_flag(rollover_flag[c]),
        .wrap_pulse   (wrap_pulse[c])
      );
    end
  endgenerate

  assign wrap_any = |wrap_pulse;

endmodule

// File: tb/tb_flex_counter_multi.sv
// tb/tb_flex_counter_multi.sv - scoreboard bench for flex_counter_multi (honours FLEX_CNT_PRESCALE_EN)
module tb_flex_counter_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] clear, load, count_enable, dir;
  logic [7:0] start_val, rollover_val, load_val;
  logic [7:0] count_out;
  logic [1:0] rollover_flag, wrap_pulse;
  logic       wrap_any;
`ifdef FLEX_CNT_PRESCALE_EN
  logic [7:0] prescale_val;
`endif

  always #5 clk = ~clk;

  flex_counter_multi #(
    .NUM_CNT_BITS(4),
    .NUM_CH      (2),
    .PRESCALE_W  (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .load         (load),
    .count_enable (count_enable),
    .dir          (dir),
    .start_val    (start_val),
    .rollover_val (rollover_val),
    .load_val     (load_val),
`ifdef FLEX_CNT_PRESCALE_EN
    .prescale_val (prescale_val),
`endif
    .count_out    (count_out),
    .rollover_flag(rollover_flag),
    .wrap_pulse   (wrap_pulse),
    .wrap_any     (wrap_any)
  );

  typedef struct {
    string      name;
    logic [1:0] mask;
    logic [3:0] c0;
    logic [3:0] c1;
    logic [1:0] f;
    logic [1:0] p;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int ch, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s ch%0d got %0d want %0d", name, ch, got, want);
    end
  endtask

  // Monitor: one registered result per clock, compared against the oldest expectation
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      for (int c = 0; c < 2; c++) begin
        if (mon_e.mask[c]) begin
          chk({mon_e.name, " count"}, c, int'(count_out[c*4 +: 4]), int'(c == 0 ? mon_e.c0 : mon_e.c1));
          chk({mon_e.name, " flag"}, c, int'(rollover_flag[c]), int'(mon_e.f[c]));
          chk({mon_e.name, " pulse"}, c, int'(wrap_pulse[c]), int'(mon_e.p[c]));
        end
      end
      if (mon_e.mask == 2'b11) chk({mon_e.name, " wrap_any"}, 0, int'(wrap_any), int'(|mon_e.p));
    end
  end

  // Queue the expected post-edge state for the inputs already applied, then advance one clock
  task automatic cyc(input string name, input logic [1:0] mask, input logic [3:0] c0,
                     input logic [3:0] c1, input logic [1:0] f, input logic [1:0] p);
    exp_t e;
    e.name = name; e.mask = mask; e.c0 = c0; e.c1 = c1; e.f = f; e.p = p;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [3:0] t0 [14] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0, 4'd1, 4'd2};
  logic [3:0] t1 [14] = '{4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3};
  logic [3:0] t4 [11] = '{4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd10};

  initial begin
    logic [3:0] v;
    logic       pl;
    rst          = 1'b1;
    clear        = 2'b00;
    load         = 2'b00;
    count_enable = 2'b00;
    dir          = 2'b10;
    start_val    = {4'd9, 4'd5};
    rollover_val = {4'd2, 4'd5};
    load_val     = 8'd0;
`ifdef FLEX_CNT_PRESCALE_EN
    prescale_val = 8'd0;
`endif
    // Reset: flag stays low even though start == rollover on ch0
    cyc("rst_start_eq_roll", 2'b11, 4'd5, 4'd9, 2'b00, 2'b00);
    start_val[3:0] = 4'd0;
    cyc("rst", 2'b11, 4'd0, 4'd9, 2'b00, 2'b00);

    // ch0 up 0..5, ch1 down 9..2, concurrently
    rst = 1'b0;
    count_enable = 2'b11;
    for (int i = 0; i < 14; i++)
      cyc("run_up_down", 2'b11, t0[i], t1[i], {t1[i] == 4'd2, t0[i] == 4'd5},
          {i == 7, (i == 5) || (i == 11)});

    // Clear/load priority
    count_enable = 2'b01;
    cyc("to_three", 2'b11, 4'd3, 4'd3, 2'b00, 2'b00);
    count_enable = 2'b00;
    clear = 2'b01; load = 2'b01; load_val[3:0] = 4'd7;
    cyc("clear_beats_load", 2'b11, 4'd0, 4'd3, 2'b00, 2'b00);
    clear = 2'b00;
    cyc("load", 2'b11, 4'd7, 4'd3, 2'b00, 2'b00);
    load_val[3:0] = 4'd5;
    cyc("load_flag", 2'b11, 4'd5, 4'd3, 2'b01, 2'b00);
    load = 2'b00; clear = 2'b01;
    cyc("clear", 2'b11, 4'd0, 4'd3, 2'b00, 2'b00);
    clear = 2'b00;
    count_enable = 2'b10; load = 2'b10; load_val[7:4] = 4'd2;
    cyc("load_beats_count", 2'b11, 4'd0, 4'd2, 2'b10, 2'b00);
    load = 2'b00;
    cyc("wrap_after_load", 2'b11, 4'd0, 4'd9, 2'b00, 2'b10);
    count_enable = 2'b00;

    // Unreachable-looking rollover: start 10, roll 4 runs through 15->0
    start_val[3:0] = 4'd10; rollover_val[3:0] = 4'd4; clear = 2'b01;
    cyc("clear_to_10", 2'b01, 4'd10, 4'd0, 2'b00, 2'b00);
    clear = 2'b00; count_enable = 2'b01;
    for (int i = 0; i < 11; i++)
      cyc("natural_wrap", 2'b01, t4[i], 4'd0, {1'b0, t4[i] == 4'd4}, {1'b0, i == 10});

    // Reset mid-count, including with a wrap pending
    count_enable = 2'b00;
    start_val[3:0] = 4'd0; rollover_val[3:0] = 4'd5; clear = 2'b01;
    cyc("clear_to_0", 2'b01, 4'd0, 4'd0, 2'b00, 2'b00);
    clear = 2'b00; count_enable = 2'b11;
    for (int i = 1; i <= 4; i++)
      cyc("pre_rst", 2'b01, 4'(i), 4'd0, 2'b00, 2'b00);
    rst = 1'b1;
    cyc("rst_at_4", 2'b11, 4'd0, 4'd9, 2'b00, 2'b00);
    rst = 1'b0; count_enable = 2'b01;
    for (int i = 1; i <= 5; i++)
      cyc("pre_rst2", 2'b01, 4'(i), 4'd0, {1'b0, i == 5}, 2'b00);
    rst = 1'b1;
    cyc("rst_at_roll", 2'b11, 4'd0, 4'd9, 2'b00, 2'b00);

    // Prescaled stepping (every cycle without the prescaler)
    count_enable = 2'b00; rollover_val[3:0] = 4'd3;
`ifdef FLEX_CNT_PRESCALE_EN
    prescale_val = 8'd2;
`endif
    cyc("rst_pre", 2'b11, 4'd0, 4'd9, 2'b00, 2'b00);
    rst = 1'b0; count_enable = 2'b01;
    for (int i = 1; i <= 12; i++) begin
`ifdef FLEX_CNT_PRESCALE_EN
      v  = 4'((i / 3) % 4);
      pl = (i == 12);
`else
      v  = 4'(i % 4);
      pl = (i % 4 == 0);
`endif
      cyc("prescale", 2'b01, v, 4'd0, {1'b0, v == 4'd3}, {1'b0, pl});
    end
    count_enable = 2'b00;

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain pending %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
